// File: rtl/ahb_lsu_port.sv
// ahb_lsu_port: bus-side load/store port sitting directly after the memory-access stage.
// Each accepted request becomes one AHB-lite transfer. Only one transfer is in flight at a
// time, and the upstream pipeline is held off through `stall` while one is.
//
// Ports:
//   CLK, RST_N        clock (rising edge) and asynchronous active-low reset
//   req_*             request handshake and fields: load/store, byte address,
//                     right-justified store data, size, unsigned flag, rd
//   HADDR .. HWDATA   AHB-lite master outputs
//   HRDATA, HREADY,   AHB-lite slave inputs
//   HRESP
//   resp_*            one-cycle completion pulse carrying the extended load data,
//                     the rd, and an error flag (misaligned access or bus error)
//   stall             ~req_ready, for the upstream pipeline

module ahb_lsu_port #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              CLK,
    input  logic              RST_N,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [4:0]        req_rd,

    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP,

    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_err,
    output logic              stall
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q, state_d;

    // Request fields, captured at accept and held for the whole transfer.
    logic [ADDR_W-1:0]   haddr_q, haddr_d;
    logic                hwrite_q, hwrite_d;
    logic [1:0]          hsize_q, hsize_d;
    logic [DATA_W-1:0]   hwdata_q, hwdata_d;
    logic                unsigned_q, unsigned_d;
    logic [4:0]          rd_q, rd_d;

    // Response registers.
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic [4:0]          resp_rd_q, resp_rd_d;
    logic                resp_err_q, resp_err_d;

    logic [DATA_W-1:0]   load_ext;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = addr_lo[0];
            2'd2:    mis = |addr_lo[1:0];
            default: mis = |addr_lo[2:0];
        endcase
        return mis;
    endfunction

    // Store data is replicated across every lane of its size so the slave can pick
    // whichever lane the address selects without us steering bytes.
    function automatic logic [63:0] replicate(input logic [63:0] wdata, input logic [1:0] size);
        logic [63:0] rep;
        case (size)
            2'd0:    rep = {8{wdata[7:0]}};
            2'd1:    rep = {4{wdata[15:0]}};
            2'd2:    rep = {2{wdata[31:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] size,
                                           input logic is_unsigned);
        logic [63:0] ext;
        case (size)
            2'd0: ext = is_unsigned ? {56'b0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            2'd1: ext = is_unsigned ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2: ext = is_unsigned ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: ext = raw;
        endcase
        return ext;
    endfunction

    // ------------------------------------------------------------------
    // Load data alignment: bring the addressed lane down to bit 0, then extend.
    // ------------------------------------------------------------------
    always_comb begin
        logic [DATA_W-1:0] shifted;
        shifted  = HRDATA >> {haddr_q[2:0], 3'b000};
        load_ext = extend(shifted, hsize_q, unsigned_q);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        haddr_d      = haddr_q;
        hwrite_d     = hwrite_q;
        hsize_d      = hsize_q;
        hwdata_d     = hwdata_q;
        unsigned_d   = unsigned_q;
        rd_d         = rd_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (is_misaligned(req_addr[2:0], req_size)) begin
                        // Rejected locally: the bus never sees this request.
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = '0;
                        resp_rd_d    = req_rd;
                    end else begin
                        state_d    = StAddr;
                        haddr_d    = req_addr;
                        hwrite_d   = ~req_load;
                        hsize_d    = req_size;
                        hwdata_d   = req_load ? '0 : replicate(req_wdata, req_size);
                        unsigned_d = req_unsigned;
                        rd_d       = req_rd;
                    end
                end
            end

            StAddr: begin
                if (HREADY) begin
                    state_d = StData;
                end
            end

            StData: begin
                // HRESP is only meaningful at the completing edge; an early HRESP
                // during the wait (first half of an error response) is ignored.
                if (HREADY) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b1;
                    resp_rd_d    = rd_q;
                    resp_err_d   = HRESP;
                    resp_data_d  = (HRESP || hwrite_q) ? '0 : load_ext;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= StIdle;
            haddr_q      <= '0;
            hwrite_q     <= 1'b0;
            hsize_q      <= 2'd0;
            hwdata_q     <= '0;
            unsigned_q   <= 1'b0;
            rd_q         <= 5'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_rd_q    <= 5'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            haddr_q      <= haddr_d;
            hwrite_q     <= hwrite_d;
            hsize_q      <= hsize_d;
            hwdata_q     <= hwdata_d;
            unsigned_q   <= unsigned_d;
            rd_q         <= rd_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready  = (state_q == StIdle);
    assign stall      = ~req_ready;

    assign HTRANS     = (state_q == StAddr) ? TransNonseq : TransIdle;
    assign HADDR      = haddr_q;
    assign HWRITE     = hwrite_q;
    assign HSIZE      = {1'b0, hsize_q};
    assign HWDATA     = hwdata_q;

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_rd    = resp_rd_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ahb_lsu_port.sv
// Directed bench for ahb_lsu_port: a linear sequence of load/store transactions with
// hand-computed expectations, checked by immediate assertions one cycle step at a time.

module tb_ahb_lsu_port;

    logic        CLK;
    logic        RST_N;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [4:0]  req_rd;
    logic [63:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        stall;

    int passed = 0;
    int total  = 0;

    ahb_lsu_port #(
        .ADDR_W(64),
        .DATA_W(64)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_load     (req_load),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_rd       (req_rd),
        .HADDR        (HADDR),
        .HWRITE       (HWRITE),
        .HTRANS       (HTRANS),
        .HSIZE        (HSIZE),
        .HWDATA       (HWDATA),
        .HRDATA       (HRDATA),
        .HREADY       (HREADY),
        .HRESP        (HRESP),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_rd      (resp_rd),
        .resp_err     (resp_err),
        .stall        (stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive_req(input logic ld, input logic [63:0] addr, input logic [63:0] wd,
                             input logic [1:0] size, input logic uns, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_load     = ld;
        req_addr     = addr;
        req_wdata    = wd;
        req_size     = size;
        req_unsigned = uns;
        req_rd       = rd;
    endtask

    initial begin
        RST_N        = 1'b0;
        req_valid    = 1'b0;
        req_load     = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_rd       = 5'd0;
        HRDATA       = '0;
        HREADY       = 1'b1;
        HRESP        = 1'b0;

        // ---- reset state ----
        step();
        step();
        chk("rst_htrans", 64'(HTRANS), 64'h0);
        chk("rst_haddr", HADDR, 64'h0);
        chk("rst_hwrite", 64'(HWRITE), 64'h0);
        chk("rst_hsize", 64'(HSIZE), 64'h0);
        chk("rst_hwdata", HWDATA, 64'h0);
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_req_ready", 64'(req_ready), 64'h1);
        chk("rst_stall", 64'(stall), 64'h0);
        RST_N = 1'b1;
        step();

        // ---- load word, signed, zero wait states ----
        drive_req(1'b1, 64'h1004, 64'h0, 2'd2, 1'b0, 5'd5);
        HRDATA = 64'h80000001_00000000;
        step();                                 // accept edge E
        req_valid = 1'b0;
        chk("lw_addr_htrans", 64'(HTRANS), 64'h2);
        chk("lw_addr_haddr", HADDR, 64'h1004);
        chk("lw_addr_hsize", 64'(HSIZE), 64'h2);
        chk("lw_addr_hwrite", 64'(HWRITE), 64'h0);
        chk("lw_addr_stall", 64'(stall), 64'h1);
        step();                                 // data phase
        chk("lw_data_htrans", 64'(HTRANS), 64'h0);
        chk("lw_data_resp_valid", 64'(resp_valid), 64'h0);
        step();                                 // response cycle
        chk("lw_resp_valid", 64'(resp_valid), 64'h1);
        chk("lw_resp_data", resp_data, 64'hFFFFFFFF_80000001);
        chk("lw_resp_rd", 64'(resp_rd), 64'd5);
        chk("lw_resp_err", 64'(resp_err), 64'h0);
        chk("lw_resp_ready", 64'(req_ready), 64'h1);
        step();
        chk("lw_resp_pulse", 64'(resp_valid), 64'h0);

        // ---- store byte (HRDATA must be ignored) ----
        drive_req(1'b0, 64'h2003, 64'hAB, 2'd0, 1'b0, 5'd7);
        HRDATA = 64'h1111_2222_3333_4444;
        step();
        req_valid = 1'b0;
        chk("sb_addr_hwrite", 64'(HWRITE), 64'h1);
        chk("sb_addr_hsize", 64'(HSIZE), 64'h0);
        chk("sb_addr_htrans", 64'(HTRANS), 64'h2);
        step();
        chk("sb_data_hwdata", HWDATA, 64'hABABABAB_ABABABAB);
        step();
        chk("sb_resp_valid", 64'(resp_valid), 64'h1);
        chk("sb_resp_data", resp_data, 64'h0);
        chk("sb_resp_err", 64'(resp_err), 64'h0);
        chk("sb_resp_rd", 64'(resp_rd), 64'd7);

        // ---- load half unsigned with wait states, issued in the response cycle ----
        drive_req(1'b1, 64'h3006, 64'h0, 2'd1, 1'b1, 5'd9);
        HRDATA = 64'hBEEF0000_00000000;
        HREADY = 1'b0;
        step();                                 // accept edge E (back-to-back)
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("lh_wait_addr_htrans", 64'(HTRANS), 64'h2);
            chk("lh_wait_addr_haddr", HADDR, 64'h3006);
            chk("lh_wait_addr_hsize", 64'(HSIZE), 64'h1);
            chk("lh_wait_addr_stall", 64'(stall), 64'h1);
            step();
        end
        chk("lh_wait_addr_held", 64'(HTRANS), 64'h2);
        chk("lh_wait_addr_haddr_held", HADDR, 64'h3006);
        HREADY = 1'b1;
        step();                                 // into data phase
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("lh_wait_data_htrans", 64'(HTRANS), 64'h0);
            chk("lh_wait_data_stall", 64'(stall), 64'h1);
            chk("lh_wait_data_resp_valid", 64'(resp_valid), 64'h0);
            step();
        end
        chk("lh_last_wait_stall", 64'(stall), 64'h1);
        HREADY = 1'b1;
        step();                                 // completion
        chk("lh_resp_valid", 64'(resp_valid), 64'h1);
        chk("lh_resp_data", resp_data, 64'h000000000000BEEF);
        chk("lh_resp_rd", 64'(resp_rd), 64'd9);
        chk("lh_resp_err", 64'(resp_err), 64'h0);
        step();

        // ---- misaligned load double ----
        drive_req(1'b1, 64'h4004, 64'h0, 2'd3, 1'b0, 5'd3);
        step();
        req_valid = 1'b0;
        chk("mis_htrans", 64'(HTRANS), 64'h0);
        chk("mis_resp_valid", 64'(resp_valid), 64'h1);
        chk("mis_resp_err", 64'(resp_err), 64'h1);
        chk("mis_resp_data", resp_data, 64'h0);
        chk("mis_req_ready", 64'(req_ready), 64'h1);
        step();
        chk("mis_pulse", 64'(resp_valid), 64'h0);
        chk("mis_no_transfer", 64'(HTRANS), 64'h0);

        // ---- load with two-cycle bus error response ----
        drive_req(1'b1, 64'h5000, 64'h0, 2'd2, 1'b0, 5'd11);
        HRDATA = 64'h00000000_12345678;
        step();
        req_valid = 1'b0;
        step();                                 // data phase
        HREADY = 1'b0;
        HRESP  = 1'b1;
        step();                                 // early HRESP ignored
        chk("err_wait_resp_valid", 64'(resp_valid), 64'h0);
        chk("err_wait_stall", 64'(stall), 64'h1);
        HREADY = 1'b1;
        step();
        HRESP = 1'b0;
        chk("err_resp_valid", 64'(resp_valid), 64'h1);
        chk("err_resp_err", 64'(resp_err), 64'h1);
        chk("err_resp_data", resp_data, 64'h0);
        chk("err_resp_rd", 64'(resp_rd), 64'd11);
        step();
        chk("err_single_pulse", 64'(resp_valid), 64'h0);

        // ---- store word replication ----
        drive_req(1'b0, 64'h8004, 64'hDEADBEEF_CAFEF00D, 2'd2, 1'b0, 5'd1);
        step();
        req_valid = 1'b0;
        step();
        chk("sw_data_hwdata", HWDATA, 64'hCAFEF00D_CAFEF00D);
        step();
        chk("sw_resp_valid", 64'(resp_valid), 64'h1);
        step();

        // ---- reset during data phase ----
        drive_req(1'b1, 64'h6000, 64'h0, 2'd2, 1'b0, 5'd12);
        step();
        req_valid = 1'b0;
        step();                                 // in data phase
        RST_N = 1'b0;
        #1;
        chk("rstmid_htrans", 64'(HTRANS), 64'h0);
        chk("rstmid_haddr", HADDR, 64'h0);
        chk("rstmid_hsize", 64'(HSIZE), 64'h0);
        chk("rstmid_resp_valid", 64'(resp_valid), 64'h0);
        chk("rstmid_req_ready", 64'(req_ready), 64'h1);
        step();
        step();
        chk("rstmid_no_resp", 64'(resp_valid), 64'h0);
        RST_N = 1'b1;
        step();

        // ---- normal load double after reset release ----
        drive_req(1'b1, 64'h7000, 64'h0, 2'd3, 1'b1, 5'd13);
        HRDATA = 64'h01234567_89ABCDEF;
        step();
        req_valid = 1'b0;
        chk("post_addr_haddr", HADDR, 64'h7000);
        chk("post_addr_hsize", 64'(HSIZE), 64'h3);
        step();
        step();
        chk("post_resp_valid", 64'(resp_valid), 64'h1);
        chk("post_resp_data", resp_data, 64'h01234567_89ABCDEF);
        chk("post_resp_rd", 64'(resp_rd), 64'd13);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
